// File: rtl/membus_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory bus arbiter.
// State type S_CPU/S_STEAL, default starve limit, default debug address ceiling.
package membus_arbiter_pkg;

   typedef enum logic {
      S_CPU   = 1'b0,
      S_STEAL = 1'b1
   } arb_state_e;

   localparam int          STARVE_LIMIT_DEF = 4;
   localparam logic [31:0] DBG_ADDR_MAX_DEF = 32'h0000_07FC;

endpackage

// File: rtl/membus_arbiter.sv
// Data-memory bus arbiter: CPU owns the bus, debug port uses idle slots
// and forces a one-cycle CPU stall after STARVE_LIMIT blocked cycles.
// Ports: clk, reset (sync, active-high); cpu_* primary port with cpu_stall;
// dbg_* secondary request/grant/read-return port; mem_* to data memory.
module membus_arbiter
   import membus_arbiter_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter logic [ADDR_W-1:0] DBG_ADDR_MAX = ADDR_W'(DBG_ADDR_MAX_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   arb_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             cpu_busy;
   logic             addr_bad;
   logic             grant;
   logic             rd_take;

   assign cpu_busy  = cpu_read | cpu_write;
   assign addr_bad  = dbg_addr > DBG_ADDR_MAX;
   assign cnt_inc   = cnt + 1'b1;
   assign cpu_rdata = mem_rdata;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant     = 1'b0;
      cpu_stall = 1'b0;
      mem_read  = cpu_read;
      mem_write = cpu_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      // Reset holds the bus with the CPU and suppresses all pulses.
      if (!reset) begin
         unique case (state)
            S_CPU: begin
               if (dbg_req && !cpu_busy) begin
                  grant   = 1'b1;
                  cnt_nxt = '0;
               end else if (dbg_req) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
                     state_nxt = S_STEAL;
                     cnt_nxt   = '0;
                  end
               end else begin
                  cnt_nxt = '0;
               end
            end
            S_STEAL: begin
               // CPU is frozen; a dropped request just burns the slot.
               cpu_stall = 1'b1;
               mem_read  = 1'b0;
               mem_write = 1'b0;
               grant     = dbg_req;
               cnt_nxt   = '0;
               state_nxt = S_CPU;
            end
            default: state_nxt = S_CPU;
         endcase
      end
      if (grant) begin
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         mem_read  = !addr_bad && !dbg_we;
         mem_write = !addr_bad && dbg_we;
      end
   end

   assign dbg_gnt = grant;
   assign dbg_err = grant & addr_bad;
   assign rd_take = grant & !addr_bad & !dbg_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_CPU;
         cnt        <= '0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         dbg_rvalid <= rd_take;
         if (rd_take) dbg_rdata <= mem_rdata;
      end
   end

endmodule
